// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ctrl
// Description : Parametrised single-clock FIFO with occupancy count,
//               programmable almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags, synchronous flush and a defined
//               simultaneous read/write at the full boundary.
//               Compile-time option SYNC_FIFO_FWFT_EN selects a
//               first-word-fall-through read port; when undefined the read
//               port is registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       flush,
    input  logic                       clr_err,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF_THRESH = CW'(AF_THRESH);
    localparam logic [CW-1:0] C_AE_THRESH = CW'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_set;
    logic             w_udf_set;

    // Status flags decode straight from the count register.
    assign w_full       = (r_count == C_DEPTH);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AF_THRESH);
    assign almost_empty = (r_count <= C_AE_THRESH);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Flush wins over both requests: they are neither accepted nor flagged.
    // A write at full rides on a same-cycle accepted read; an empty FIFO
    // never bypasses a write to the read side.
    assign w_rd_acc  = !flush && rd_en && !w_empty;
    assign w_wr_acc  = !flush && wr_en && (!w_full || w_rd_acc);
    assign w_ovf_set = !flush && wr_en && !w_wr_acc;
    assign w_udf_set = !flush && rd_en && !w_rd_acc;

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown combinationally; rd_en acknowledges it.
    assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
    assign dout_valid = !w_empty;
`else
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    // Registered read port: valid pulses for the cycle after each pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (flush) begin
            r_dout_valid <= 1'b0;
        end else if (w_rd_acc) begin
            r_dout       <= r_mem[r_rd_ptr];
            r_dout_valid <= 1'b1;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_ctrl
// Description : Directed self-checking bench for sync_fifo_ctrl covering
//               fill/drain, full and empty boundaries, thresholds, flush,
//               asynchronous reset and the read-port mode selected by
//               SYNC_FIFO_FWFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [4:0]       count;
    logic             flush;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    int n_checks = 0;
    int n_errors = 0;

    sync_fifo_ctrl #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(14),
        .AE_THRESH(2)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .flush       (flush),
        .clr_err     (clr_err),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: inputs set before the call are sampled, outputs settle #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one word and compare it, in whichever read mode is built.
    task automatic read_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_vld"}, 32'(dout_valid), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_dout"}, 32'(dout), 32'(exp));
        check({tag, "_vld"}, 32'(dout_valid), 32'd1);
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        din     = '0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        #23;
        // Reset values
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_vld", 32'(dout_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_udf", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fill 0x00..0x0F with threshold checks on the way up
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            tick();
            if (i == 0) check("ae_at_1", 32'(almost_empty), 32'd1);
            if (i == 1) check("ae_at_2", 32'(almost_empty), 32'd1);
            if (i == 2) check("ae_at_3", 32'(almost_empty), 32'd0);
            if (i == 12) check("af_at_13", 32'(almost_full), 32'd0);
            if (i == 13) check("af_at_14", 32'(almost_full), 32'd1);
            if (i == 14) check("full_at_15", 32'(full), 32'd0);
        end
        wr_en = 1'b0;
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        check("fill_empty", 32'(empty), 32'd0);

        // Rejected write at full
        wr_en = 1'b1;
        din   = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous read/write at full
`ifdef SYNC_FIFO_FWFT_EN
        check("fb_head", 32'(dout), 32'h00);
`endif
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 8'h55;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check("fb_dout", 32'(dout), 32'h00);
`endif
        check("fb_count", 32'(count), 32'd16);
        check("fb_ovf", 32'(overflow), 32'd0);

        // Drain: 0x01..0x0F then the wrapped 0x55
        for (int i = 1; i < 16; i++) begin
            read_check($sformatf("drain%0d", i), 8'(i));
        end
        read_check("drain_55", 8'h55);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
        tick();
        check("idle_vld", 32'(dout_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("idle_hold", 32'(dout), 32'h55);
`endif

        // Empty boundary: read rejected, write accepted
        rd_en = 1'b1;
        wr_en = 1'b1;
        din   = 8'h33;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check("eb_udf", 32'(underflow), 32'd1);
        check("eb_count", 32'(count), 32'd1);
        read_check("eb_33", 8'h33);
        // Set beats clear in the same cycle
        rd_en   = 1'b1;
        clr_err = 1'b1;
        tick();
        rd_en   = 1'b0;
        check("udf_setwins", 32'(underflow), 32'd1);
        tick();
        clr_err = 1'b0;
        check("udf_clr", 32'(underflow), 32'd0);

        // Flush with a coincident write
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h40 + i);
            tick();
        end
        wr_en = 1'b0;
        check("pre_flush_cnt", 32'(count), 32'd5);
        flush = 1'b1;
        wr_en = 1'b1;
        din   = 8'h99;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_ovf", 32'(overflow), 32'd0);
        check("flush_udf", 32'(underflow), 32'd0);
        check("flush_vld", 32'(dout_valid), 32'd0);

        // Refill three words; pointers must restart from zero
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            din   = 8'(8'h61 + i);
            tick();
        end
        wr_en = 1'b0;
        check("refill_count", 32'(count), 32'd3);
        read_check("refill_61", 8'h61);

        // Asynchronous reset mid-stream, checked before the next edge
        wr_en = 1'b1;
        din   = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_ae", 32'(almost_empty), 32'd1);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_vld", 32'(dout_valid), 32'd0);
        wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SYNC_FIFO_FWFT_EN
        // First word falls through one cycle after its write
        wr_en = 1'b1;
        din   = 8'h12;
        tick();
        check("fwft_first", 32'(dout), 32'h12);
        check("fwft_vld", 32'(dout_valid), 32'd1);
        din   = 8'h34;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        check("fwft_second", 32'(dout), 32'h34);
        tick();
        rd_en = 1'b0;
        check("fwft_done_vld", 32'(dout_valid), 32'd0);
        check("fwft_done_dout", 32'(dout), 32'd0);
`else
        // One-cycle read latency and single-cycle valid pulse
        wr_en = 1'b1;
        din   = 8'h12;
        tick();
        wr_en = 1'b0;
        check("lat_novld", 32'(dout_valid), 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("lat_dout", 32'(dout), 32'h12);
        check("lat_vld", 32'(dout_valid), 32'd1);
        tick();
        check("lat_vld_drop", 32'(dout_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised synchronous FIFO. It is the next-generation buffer for the UART TX/RX paths.
It adds over the basic FIFO:
- programmable almost-full/almost-empty thresholds
- occupancy count output
- sticky overflow/underflow error flags
- synchronous flush
- defined simultaneous read/write at the full boundary
- compile-time first-word-fall-through (FWFT) read mode

It sits between the UART byte engines and the host-side register interface.

Parameters:
WIDTH, 8, data word width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  write request.
din  input  WIDTH  write data.
rd_en  input  1  read request (pop).
dout  output  WIDTH  read data.
dout_valid  output  1  dout holds a valid word (meaning depends on mode, see Behaviour).
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
flush  input  1  synchronous flush.
clr_err  input  1  synchronous clear of sticky error flags.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr, count = 0; dout = 0; dout_valid = 0; overflow = underflow = 0.
  - empty = 1, almost_empty = 1, full = almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers: $clog2(DEPTH) bits each; wrap modulo DEPTH naturally. count is tracked explicitly.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc).
  - A write at full is accepted only if a read is accepted in the same cycle.
  - There is no bypass when empty: a read at count 0 is rejected even if a write arrives in the same cycle.
- count next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
  - count never exceeds DEPTH and never underflows.
- Flags: full, empty, almost_full and almost_empty are combinational from the count register, so they update the cycle after the accepting edge.
- Errors:
  - overflow sets on wr_en && !wr_acc.
  - underflow sets on rd_en && !rd_acc.
  - Both hold until clr_err. If a set condition and clr_err occur in the same cycle, set wins.
- flush:
  - Pointers and count go to 0 next edge.
  - Has priority over wr_en/rd_en in the same cycle: those requests are dropped and do not set error flags.
  - dout_valid is forced to 0; dout holds its value; sticky flags are unaffected.
- Standard read mode (macro undefined):
  - On rd_acc, dout <= mem[rd_ptr] at that edge and dout_valid = 1 for exactly the following cycle.
  - Read latency is 1 cycle. dout holds its last value otherwise.
- Write data is stored at mem[wr_ptr] on the wr_acc edge. A word written in cycle N is readable via rd_en from cycle N+1.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN.
- Defined (FWFT mode):
  - dout = mem[rd_ptr] combinationally, or 0 when empty.
  - dout_valid = !empty.
  - rd_en acts as a pop acknowledge of the currently shown word, with the same rd_acc rules.
  - The first word appears on dout the cycle after its write edge.
  - Flush forces dout_valid low via empty.
- Undefined: the standard registered read with 1-cycle latency described above.

Test Plan:
- Fill/drain:
  - Stimulus: write 0x00..0x0F on consecutive cycles, then write 0xAA once more; then read 16 times.
  - Response: full = 1 and count = 16 after the 16th write; 0xAA is rejected and overflow = 1; reads return 0x00..0x0F in order; empty = 1 and count = 0 at the end; overflow stays 1 until a clr_err pulse clears it.
- Full boundary:
  - Stimulus: at count = 16, assert wr_en (din = 0x55) and rd_en together.
  - Response: both accepted; count stays 16; overflow stays 0; 0x55 is read last after wrap-around.
- Thresholds:
  - Stimulus: AF_THRESH = 14, AE_THRESH = 2; write incrementally.
  - Response: almost_empty is 1 at counts 0..2 and 0 at count 3; almost_full is 0 at count 13 and 1 at count 14.
- Empty boundary:
  - Stimulus: at count = 0, assert rd_en and wr_en (din = 0x33) together.
  - Response: read is rejected and underflow = 1; write is accepted and count = 1; the next rd_en returns 0x33.
- Flush and reset:
  - Stimulus: with count = 5, pulse flush together with wr_en; then refill 3 words; then pulse rst_n low mid-stream.
  - Response: after flush, count = 0 and empty = 1, the write is dropped and no error flag is set; after rst_n low, all outputs are at reset values asynchronously, before the next clk edge.
- FWFT (macro defined):
  - Stimulus: write 0x12, then 0x34.
  - Response: the cycle after the first write, dout = 0x12 and dout_valid = 1; after one rd_en, dout = 0x34; after a second rd_en, dout_valid = 0 and dout = 0.
